// File: rtl/bcd_stopwatch.sv
// BCD mm:ss up/down stopwatch driven by the clock divider's slow square wave.
// tick_in is synchronized and edge-detected; every TICKS_PER_STEP edges form one count step.
module bcd_stopwatch #(
   parameter int TICKS_PER_STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_in,
   input  logic        start_pause,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_bcd,
   input  logic        mode_down,
   output logic [3:0]  min_tens,
   output logic [3:0]  min_ones,
   output logic [3:0]  sec_tens,
   output logic [3:0]  sec_ones,
   output logic        running,
   output logic        done,
   output logic        tick_pulse
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   localparam logic [7:0] STEP_LAST = 8'(TICKS_PER_STEP - 1);

   state_t      state, state_nxt;
   logic [15:0] time_q, time_nxt;
   logic [7:0]  presc, presc_nxt;
   logic        done_nxt;
   logic        s1, s2, s3;
   logic        is_zero, load_ok;

   // Increment {mt,mo,st,so}; each digit only advances when all lower digits wrap.
   function automatic logic [15:0] bcd_inc(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = t;
      if (so != 4'd9) so = so + 4'd1;
      else begin
         so = 4'd0;
         if (st != 4'd5) st = st + 4'd1;
         else begin
            st = 4'd0;
            if (mo != 4'd9) mo = mo + 4'd1;
            else begin
               mo = 4'd0;
               mt = (mt != 4'd5) ? mt + 4'd1 : 4'd0;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = t;
      if (so != 4'd0) so = so - 4'd1;
      else begin
         so = 4'd9;
         if (st != 4'd0) st = st - 4'd1;
         else begin
            st = 4'd5;
            if (mo != 4'd0) mo = mo - 4'd1;
            else begin
               mo = 4'd9;
               mt = (mt != 4'd0) ? mt - 4'd1 : 4'd5;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   assign is_zero    = (time_q == 16'h0000);
   assign load_ok    = (load_bcd[15:12] <= 4'd5) && (load_bcd[11:8] <= 4'd9) &&
                       (load_bcd[7:4]   <= 4'd5) && (load_bcd[3:0]  <= 4'd9);
   assign tick_pulse = s2 & ~s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= tick_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         time_q  <= 16'h0000;
         presc   <= 8'd0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         time_q  <= time_nxt;
         presc   <= presc_nxt;
         running <= (state_nxt == RUN);
         done    <= done_nxt;
      end
   end

   // Priority: clear > accepted load > start_pause > count step.
   always_comb begin
      state_nxt = state;
      time_nxt  = time_q;
      presc_nxt = presc;
      done_nxt  = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
         time_nxt  = 16'h0000;
         presc_nxt = 8'd0;
      end else if (load && (state != RUN) && load_ok) begin
         state_nxt = IDLE;
         time_nxt  = load_bcd;
         presc_nxt = 8'd0;
      end else if (start_pause) begin
         case (state)
            IDLE, PAUSE: if (!(mode_down && is_zero)) state_nxt = RUN;
            RUN:         state_nxt = PAUSE;
            default:     state_nxt = state;
         endcase
      end else if ((state == RUN) && tick_pulse) begin
         if (presc == STEP_LAST) begin
            presc_nxt = 8'd0;
            if (!mode_down) begin
               time_nxt = bcd_inc(time_q);
            end else if (is_zero || (time_q == 16'h0001)) begin
               // A countdown never wraps below 00:00; it parks in DONE.
               time_nxt  = 16'h0000;
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else begin
               time_nxt = bcd_dec(time_q);
            end
         end else begin
            presc_nxt = presc + 8'd1;
         end
      end
   end

   assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: one instance with single-tick steps, one with four ticks per step.
module tb_bcd_stopwatch;

   logic        clk = 1'b0;
   logic        rst, tick_in, start_pause, clear, load, mode_down;
   logic [15:0] load_bcd;
   logic [3:0]  mt1, mo1, st1, so1, mt4, mo4, st4, so4;
   logic        running1, done1, tp1, running4, done4, tp4;
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;

   always #5 clk = ~clk;

   bcd_stopwatch #(.TICKS_PER_STEP(1)) dut (
      .clk(clk), .rst(rst), .tick_in(tick_in), .start_pause(start_pause), .clear(clear),
      .load(load), .load_bcd(load_bcd), .mode_down(mode_down),
      .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
      .running(running1), .done(done1), .tick_pulse(tp1));

   bcd_stopwatch #(.TICKS_PER_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .tick_in(tick_in), .start_pause(start_pause), .clear(clear),
      .load(load), .load_bcd(load_bcd), .mode_down(mode_down),
      .min_tens(mt4), .min_ones(mo4), .sec_tens(st4), .sec_ones(so4),
      .running(running4), .done(done4), .tick_pulse(tp4));

   always @(negedge clk) if (done1) done_cnt++;

   task automatic do_start();
      @(negedge clk) start_pause = 1'b1;
      @(negedge clk) start_pause = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk) clear = 1'b1;
      @(negedge clk) clear = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] v);
      @(negedge clk) begin load = 1'b1; load_bcd = v; end
      @(negedge clk) load = 1'b0;
   endtask

   // One full tick_in period; the step lands two edges after tick_in is sampled high.
   task automatic do_tick();
      @(negedge clk) tick_in = 1'b1;
      repeat (3) @(negedge clk);
      tick_in = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk) rst = 1'b1;
      tick_in = 1'b1;
      @(negedge clk) tick_in = 1'b0;
      checks++;
      if ({mt1, mo1, st1, so1, running1, done1, tp1} !== 19'h0) begin
         errors++;
         $display("FAIL reset_state got %h%h%h%h run=%b done=%b tp=%b need 0000/0/0/0",
                  mt1, mo1, st1, so1, running1, done1, tp1);
      end
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i % 4 == 0) tick_in = ~tick_in;
      end
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({mt1, mo1, st1, so1, running1, mt4, mo4, st4, so4, running4} !== 34'h0) begin
         errors++;
         $display("FAIL idle_ticks got %h%h%h%h run=%b need 0000 run=0", mt1, mo1, st1, so1, running1);
      end
   endtask

   task automatic test_up_count();
      logic [15:0] exp_old, exp_new;
      mode_down = 1'b0;
      do_start();
      checks++;
      if (running1 !== 1'b1) begin
         errors++;
         $display("FAIL up_start running got %b need 1", running1);
      end
      for (int i = 0; i < 10; i++) begin
         exp_old = {8'h00, 4'(i / 10), 4'(i % 10)};
         exp_new = {8'h00, 4'((i + 1) / 10), 4'((i + 1) % 10)};
         @(negedge clk) tick_in = 1'b1;
         @(negedge clk);
         @(negedge clk);
         checks++;
         if (tp1 !== 1'b1 || {mt1, mo1, st1, so1} !== exp_old) begin
            errors++;
            $display("FAIL up_edge1 step %0d got tp=%b %h%h%h%h need tp=1 %h", i, tp1, mt1, mo1, st1, so1, exp_old);
         end
         @(negedge clk);
         checks++;
         if (tp1 !== 1'b0 || {mt1, mo1, st1, so1} !== exp_new) begin
            errors++;
            $display("FAIL up_edge2 step %0d got tp=%b %h%h%h%h need tp=0 %h", i, tp1, mt1, mo1, st1, so1, exp_new);
         end
         tick_in = 1'b0;
         repeat (2) @(negedge clk);
      end
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h0010) begin
         errors++;
         $display("FAIL up_ten got %h%h%h%h need 0010", mt1, mo1, st1, so1);
      end
   endtask

   task automatic test_wrap();
      int d0;
      do_clear();
      mode_down = 1'b0;
      do_load(16'h5958);
      do_start();
      d0 = done_cnt;
      do_tick();
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h5959) begin
         errors++;
         $display("FAIL wrap_5959 got %h%h%h%h need 5959", mt1, mo1, st1, so1);
      end
      do_tick();
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h0000 || running1 !== 1'b1 || done_cnt != d0) begin
         errors++;
         $display("FAIL wrap_0000 got %h%h%h%h run=%b dones=%0d need 0000 run=1 dones=0",
                  mt1, mo1, st1, so1, running1, done_cnt - d0);
      end
   endtask

   task automatic test_countdown();
      int d0;
      do_clear();
      mode_down = 1'b1;
      do_start();
      checks++;
      if (running1 !== 1'b0) begin
         errors++;
         $display("FAIL down_zero_start running got %b need 0", running1);
      end
      do_load(16'h0002);
      do_start();
      d0 = done_cnt;
      do_tick();
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h0001 || running1 !== 1'b1) begin
         errors++;
         $display("FAIL down_0001 got %h%h%h%h run=%b need 0001 run=1", mt1, mo1, st1, so1, running1);
      end
      @(negedge clk) tick_in = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h0000 || done1 !== 1'b1 || running1 !== 1'b0) begin
         errors++;
         $display("FAIL down_done got %h%h%h%h done=%b run=%b need 0000 done=1 run=0",
                  mt1, mo1, st1, so1, done1, running1);
      end
      @(negedge clk) tick_in = 1'b0;
      checks++;
      if (done1 !== 1'b0) begin
         errors++;
         $display("FAIL down_done_width got done=%b need 0", done1);
      end
      do_start();
      repeat (2) @(negedge clk);
      checks++;
      if (running1 !== 1'b0 || {mt1, mo1, st1, so1} !== 16'h0000 || done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL down_hold got run=%b %h%h%h%h dones=%0d need run=0 0000 dones=1",
                  running1, mt1, mo1, st1, so1, done_cnt - d0);
      end
   endtask

   task automatic test_prescaler();
      do_clear();
      mode_down = 1'b0;
      do_start();
      repeat (3) do_tick();
      checks++;
      if ({mt4, mo4, st4, so4} !== 16'h0000 || running4 !== 1'b1) begin
         errors++;
         $display("FAIL presc_3ticks got %h%h%h%h run=%b need 0000 run=1", mt4, mo4, st4, so4, running4);
      end
      do_start();
      repeat (5) do_tick();
      checks++;
      if ({mt4, mo4, st4, so4} !== 16'h0000 || running4 !== 1'b0) begin
         errors++;
         $display("FAIL presc_pause got %h%h%h%h run=%b need 0000 run=0", mt4, mo4, st4, so4, running4);
      end
      do_start();
      do_tick();
      checks++;
      if ({mt4, mo4, st4, so4} !== 16'h0001 || running4 !== 1'b1) begin
         errors++;
         $display("FAIL presc_resume got %h%h%h%h run=%b need 0001 run=1", mt4, mo4, st4, so4, running4);
      end
   endtask

   task automatic test_load();
      do_clear();
      do_load(16'h1234);
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h1234 || running1 !== 1'b0) begin
         errors++;
         $display("FAIL load_ok got %h%h%h%h run=%b need 1234 run=0", mt1, mo1, st1, so1, running1);
      end
      do_load(16'h0A00);
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h1234) begin
         errors++;
         $display("FAIL load_bad_digit got %h%h%h%h need 1234", mt1, mo1, st1, so1);
      end
      do_load(16'h0060);
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h1234) begin
         errors++;
         $display("FAIL load_bad_sec_tens got %h%h%h%h need 1234", mt1, mo1, st1, so1);
      end
      @(negedge clk) begin clear = 1'b1; load = 1'b1; load_bcd = 16'h4321; end
      @(negedge clk) begin clear = 1'b0; load = 1'b0; end
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h0000 || running1 !== 1'b0) begin
         errors++;
         $display("FAIL clear_over_load got %h%h%h%h run=%b need 0000 run=0", mt1, mo1, st1, so1, running1);
      end
      mode_down = 1'b0;
      do_load(16'h1234);
      do_start();
      do_load(16'h0500);
      checks++;
      if ({mt1, mo1, st1, so1} !== 16'h1234 || running1 !== 1'b1) begin
         errors++;
         $display("FAIL load_in_run got %h%h%h%h run=%b need 1234 run=1", mt1, mo1, st1, so1, running1);
      end
   endtask

   initial begin
      rst = 1'b1; tick_in = 1'b0; start_pause = 1'b0; clear = 1'b0;
      load = 1'b0; load_bcd = 16'h0000; mode_down = 1'b0;
      test_reset();
      test_up_count();
      test_wrap();
      test_countdown();
      test_prescaler();
      test_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Timekeeping stage directly downstream of the clock divider.
- Takes the divider's slow square-wave output as a data input, synchronizes it into the system clock domain and edge-detects it.
- Uses the resulting ticks to run a BCD mm:ss up/down timer with start/pause, clear and load controls.
- The four BCD digits feed the seven-segment display scanner; done feeds the buzzer/LED logic.

Parameters:
- TICKS_PER_STEP, 1, number of tick_in rising edges per one-second count step (1..255).

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  divided clock from the clock divider; treated as asynchronous data.
- start_pause  input  1  one-cycle pulse (already one-pulsed); toggles run/pause.
- clear  input  1  one-cycle pulse; returns to 00:00 idle.
- load  input  1  one-cycle pulse; loads load_bcd.
- load_bcd  input  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- mode_down  input  1  1 = count down, 0 = count up.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  current time digits (BCD).
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a countdown reaches 00:00.
- tick_pulse  output  1  one-cycle pulse per synchronized tick_in rising edge (debug).

Behaviour:
- All state updates on posedge clk; rst is sampled synchronously and overrides everything.
- Reset values:
  - All digits 0; running=0; done=0; tick_pulse=0.
  - State IDLE; prescaler=0; sync flops=0.
- Synchronizer:
  - s1<=tick_in, s2<=s1, s3<=s2; tick_pulse = s2 & ~s3.
  - If tick_in is first high at edge k, tick_pulse is high for the cycle between edges k+1 and k+2.
  - Digits update at edge k+2 when a step occurs.
- Prescaler (8-bit):
  - Increments on each tick_pulse in RUN only.
  - When it equals TICKS_PER_STEP-1 and tick_pulse is high: it resets to 0 and a count step fires.
  - Held (not cleared) in PAUSE.
  - Cleared by rst, clear and an accepted load.
- States:
  - IDLE: start_pause → RUN. Exception: mode_down=1 and time=00:00, in which case stay IDLE.
  - RUN: start_pause → PAUSE. A down-step from 00:01 → time 00:00, go to DONE, done=1 for exactly that cycle.
  - PAUSE: start_pause → RUN (same 00:00/down exception as IDLE); tick_in ignored.
  - DONE: start_pause ignored; digits hold 00:00.
  - clear in any state → IDLE, digits 00:00.
  - Accepted load → IDLE with the loaded digits.
- Up count:
  - sec_ones 9→0 carries into sec_tens; sec_tens 5→0 carries into min_ones; min_ones 9→0 carries into min_tens.
  - 59:59 → 00:00 wrap; no done, stays RUN.
- Down count:
  - Borrow mirror of the up count: sec 00 → 59 with minute decrement.
  - Reaching 00:00 ends in DONE as above; never wraps below 00:00.
- mode_down is sampled at each step; changing it mid-run takes effect on the next step.
- Load:
  - Accepted only in IDLE, PAUSE and DONE; ignored in RUN.
  - Rejected (no change at all) if any digit > 9, or sec_tens > 5, or min_tens > 5.
- Priority within one cycle: rst > clear > load > start_pause > count step.
  - A step coinciding with start_pause in RUN is dropped, not applied.
  - A tick coinciding with clear is discarded.
- running is a registered output equal to (state==RUN).
- done is registered, high only on the transition cycle into DONE.
- Digit outputs are registers: no combinational path from inputs to digits.

Test Plan:
- rst high 2 cycles, then tick_in toggling every 4 clk → all digits 0, running=0, no change (IDLE).
- TICKS_PER_STEP=1, up mode, start_pause, then 10 tick_in rising edges → 00:10. Bench also checks each update lands 2 edges after the sampled rise.
- load_bcd=16'h5958, up mode, start, 2 ticks → 59:59 then 00:00, running stays 1, done never asserted.
- load_bcd=16'h0002, mode_down=1, start, 2 ticks → 00:01, then 00:00 with done=1 for one cycle, running=0. A further start_pause leaves the timer in DONE.
- TICKS_PER_STEP=4, up mode:
  - 3 ticks → no step.
  - pause, 5 ticks → no change.
  - resume, 1 tick → 00:01 (prescaler preserved across pause).
- load_bcd=16'h0A00 in IDLE → rejected, digits unchanged. Same-cycle clear+load → 00:00 IDLE. Load during RUN → ignored.
